// File: rtl/despacho_pkg.sv
// Shared constants and types for the Tomasulo issue stage (despacho_multi_rs).
package despacho_pkg;

  localparam logic [2:0]  OP_NOP        = 3'b000;
  localparam int unsigned FREE_REGISTER = 0;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    STALL
  } despacho_state_t;

  // "No value yet" operand marker: all ones with the low nibble cleared.
  function automatic logic [63:0] sem_valor(input int unsigned w);
    logic [63:0] mask;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return mask & ~64'hF;
  endfunction

endpackage

// File: rtl/seletor_rs_livre.sv
// Combinational round-robin finder: first non-busy station at or after rr_ptr, wrapping mod N_RS.
module seletor_rs_livre #(
  parameter int unsigned N_RS  = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N_RS-1:0]  Busy,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [PTR_W-1:0] sel,
  output logic             found
);

  int unsigned idx;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < N_RS; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N_RS) idx = idx - N_RS;
      if (!found && !Busy[PTR_W'(idx)]) begin
        found = 1'b1;
        sel   = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/despacho_multi_rs.sv
// Issue stage: resolves operands from the register status table, allocates a reservation
// station round-robin and renames Ri. Define CDB_BYPASS_EN to forward a same-cycle CDB broadcast.
module despacho_multi_rs
  import despacho_pkg::*;
#(
  parameter int unsigned N_RS    = 4,
  parameter int unsigned N_REGS  = 8,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TAG_W   = 3,
  parameter int unsigned STALL_W = 8
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Instr_Valid,
  input  logic [15:0]              Instrucao_Despachada,
  input  logic [N_REGS*TAG_W-1:0]  Rs_Qi,
  input  logic [N_REGS*DATA_W-1:0] Rs_Qi_data,
  input  logic [N_RS-1:0]          Busy,
  input  logic                     CDB_Valid,
  input  logic [TAG_W-1:0]         CDB_Tag,
  input  logic [DATA_W-1:0]        CDB_Data,
  output logic [DATA_W-1:0]        Vj,
  output logic [DATA_W-1:0]        Vk,
  output logic [TAG_W-1:0]         Qj,
  output logic [TAG_W-1:0]         Qk,
  output logic [2:0]               Ufop,
  output logic [N_RS-1:0]          Enable_VQ,
  output logic                     R_enable_despacho,
  output logic [2:0]               R_target_despacho,
  output logic [TAG_W-1:0]         R_res_station_despacho,
  output logic                     Pop,
  output logic [STALL_W-1:0]       Stall_count
);

  localparam int unsigned       PTR_W     = (N_RS > 1) ? $clog2(N_RS) : 1;
  localparam logic [DATA_W-1:0] SEM_VALOR = DATA_W'(sem_valor(DATA_W));
  localparam logic [TAG_W-1:0]  TAG_FREE  = TAG_W'(FREE_REGISTER);

  despacho_state_t   state;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  sel;
  logic              found;
  logic [2:0]        op, ri, rj, rk;
  logic [TAG_W-1:0]  tag_j, tag_k, nxt_qj, nxt_qk;
  logic [DATA_W-1:0] nxt_vj, nxt_vk;
  logic              is_nop, hazard, do_issue, do_stall;
  logic              unused_bits;

  assign op     = Instrucao_Despachada[15:13];
  assign ri     = Instrucao_Despachada[12:10];
  assign rj     = Instrucao_Despachada[9:7];
  assign rk     = Instrucao_Despachada[6:4];
  assign is_nop = (op == OP_NOP);

  // Tags are read before this instruction's rename takes effect, so Ri==Rj sees the old producer.
  assign tag_j = Rs_Qi[rj*TAG_W +: TAG_W];
  assign tag_k = Rs_Qi[rk*TAG_W +: TAG_W];

`ifdef CDB_BYPASS_EN
  assign unused_bits = ^Instrucao_Despachada[3:0];
`else
  assign unused_bits = ^{Instrucao_Despachada[3:0], CDB_Data};
`endif

  seletor_rs_livre #(
    .N_RS  (N_RS),
    .PTR_W (PTR_W)
  ) u_seletor (
    .Busy   (Busy),
    .rr_ptr (rr_ptr),
    .sel    (sel),
    .found  (found)
  );

  always_comb begin
    nxt_vj = (tag_j == TAG_FREE) ? Rs_Qi_data[rj*DATA_W +: DATA_W] : SEM_VALOR;
    nxt_vk = (tag_k == TAG_FREE) ? Rs_Qi_data[rk*DATA_W +: DATA_W] : SEM_VALOR;
    nxt_qj = tag_j;
    nxt_qk = tag_k;
    hazard = 1'b0;
`ifdef CDB_BYPASS_EN
    if (CDB_Valid && tag_j != TAG_FREE && CDB_Tag == tag_j) begin
      nxt_vj = CDB_Data;
      nxt_qj = TAG_FREE;
    end
    if (CDB_Valid && tag_k != TAG_FREE && CDB_Tag == tag_k) begin
      nxt_vk = CDB_Data;
      nxt_qk = TAG_FREE;
    end
`else
    // Without forwarding, a producer broadcasting now would be missed; wait for the table update.
    hazard = CDB_Valid && ((tag_j != TAG_FREE && CDB_Tag == tag_j) ||
                           (tag_k != TAG_FREE && CDB_Tag == tag_k));
`endif
  end

  // A NOP needs no station and reads no operands, so it is consumed unconditionally.
  assign do_issue = Instr_Valid && (is_nop || (found && !hazard));
  assign do_stall = Instr_Valid && !do_issue;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state                  <= IDLE;
      rr_ptr                 <= '0;
      Vj                     <= SEM_VALOR;
      Vk                     <= SEM_VALOR;
      Qj                     <= '0;
      Qk                     <= '0;
      Ufop                   <= '0;
      Enable_VQ              <= '0;
      R_enable_despacho      <= 1'b0;
      R_target_despacho      <= '0;
      R_res_station_despacho <= '0;
      Pop                    <= 1'b0;
      Stall_count            <= '0;
    end else begin
      Enable_VQ         <= '0;
      R_enable_despacho <= 1'b0;
      Pop               <= do_issue;

      if (state == STALL && Stall_count != '1)
        Stall_count <= Stall_count + STALL_W'(1);

      if (do_issue)      state <= ISSUE;
      else if (do_stall) state <= STALL;
      else               state <= IDLE;

      if (do_issue && !is_nop) begin
        Vj                     <= nxt_vj;
        Vk                     <= nxt_vk;
        Qj                     <= nxt_qj;
        Qk                     <= nxt_qk;
        Ufop                   <= op;
        Enable_VQ              <= {{(N_RS-1){1'b0}}, 1'b1} << sel;
        R_enable_despacho      <= 1'b1;
        R_target_despacho      <= ri;
        R_res_station_despacho <= TAG_W'(sel) + TAG_W'(1);
        rr_ptr                 <= (sel == PTR_W'(N_RS-1)) ? '0 : sel + PTR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_despacho_multi_rs.sv
// Scoreboard bench for despacho_multi_rs (N_RS=4); expectations follow CDB_BYPASS_EN when defined.
module tb_despacho_multi_rs;

  logic         Clock = 1'b0;
  logic         Reset;
  logic         Instr_Valid;
  logic [15:0]  Instrucao_Despachada;
  logic [23:0]  Rs_Qi;
  logic [127:0] Rs_Qi_data;
  logic [3:0]   Busy;
  logic         CDB_Valid;
  logic [2:0]   CDB_Tag;
  logic [15:0]  CDB_Data;
  logic [15:0]  Vj, Vk;
  logic [2:0]   Qj, Qk, Ufop;
  logic [3:0]   Enable_VQ;
  logic         R_enable_despacho;
  logic [2:0]   R_target_despacho;
  logic [2:0]   R_res_station_despacho;
  logic         Pop;
  logic [7:0]   Stall_count;

  despacho_multi_rs #(
    .N_RS    (4),
    .N_REGS  (8),
    .DATA_W  (16),
    .TAG_W   (3),
    .STALL_W (8)
  ) dut (
    .Clock                  (Clock),
    .Reset                  (Reset),
    .Instr_Valid            (Instr_Valid),
    .Instrucao_Despachada   (Instrucao_Despachada),
    .Rs_Qi                  (Rs_Qi),
    .Rs_Qi_data             (Rs_Qi_data),
    .Busy                   (Busy),
    .CDB_Valid              (CDB_Valid),
    .CDB_Tag                (CDB_Tag),
    .CDB_Data               (CDB_Data),
    .Vj                     (Vj),
    .Vk                     (Vk),
    .Qj                     (Qj),
    .Qk                     (Qk),
    .Ufop                   (Ufop),
    .Enable_VQ              (Enable_VQ),
    .R_enable_despacho      (R_enable_despacho),
    .R_target_despacho      (R_target_despacho),
    .R_res_station_despacho (R_res_station_despacho),
    .Pop                    (Pop),
    .Stall_count            (Stall_count)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic        nop;
    logic [15:0] vj, vk;
    logic [2:0]  qj, qk, op, ri, tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [1:0]  m_rr;
  int          m_state;  // 0 idle, 1 issue, 2 stall
  logic [7:0]  m_stall;
  logic [15:0] h_vj, h_vk;
  logic [2:0]  h_qj, h_qk, h_op, h_ri, h_tag;
  logic        track_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_rr = 0; m_state = 0; m_stall = 0;
    h_vj = 16'hFFF0; h_vk = 16'hFFF0;
    h_qj = 0; h_qk = 0; h_op = 0; h_ri = 0; h_tag = 0;
    sb.delete();
  endtask

  task automatic check_reset_values();
    check("rst_vj", Vj, 16'hFFF0);
    check("rst_vk", Vk, 16'hFFF0);
    check("rst_qj", Qj, 0);
    check("rst_qk", Qk, 0);
    check("rst_ufop", Ufop, 0);
    check("rst_en_vq", Enable_VQ, 0);
    check("rst_ren", R_enable_despacho, 0);
    check("rst_rtgt", R_target_despacho, 0);
    check("rst_rtag", R_res_station_despacho, 0);
    check("rst_pop", Pop, 0);
    check("rst_stall", Stall_count, 0);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(posedge Clock); #1;
    model_reset();
    check_reset_values();
    Reset = 1'b0;
    Instr_Valid = 1'b0;
  endtask

  task automatic load(input logic [2:0] op, input logic [2:0] ri, input logic [2:0] rj,
                      input logic [2:0] rk);
    Instrucao_Despachada = {op, ri, rj, rk, 4'b0000};
    Instr_Valid = 1'b1;
  endtask

  task automatic step();
    logic [2:0] op, ri, rj, rk, tj, tk;
    logic [1:0] s;
    logic       f, haz, iss, nop;
    int         idx;
    exp_t       e;
    op = Instrucao_Despachada[15:13]; ri = Instrucao_Despachada[12:10];
    rj = Instrucao_Despachada[9:7];   rk = Instrucao_Despachada[6:4];
    tj = Rs_Qi[rj*3 +: 3];
    tk = Rs_Qi[rk*3 +: 3];
    f = 0; s = 0;
    for (int i = 0; i < 4; i++) begin
      idx = (int'(m_rr) + i) % 4;
      if (!f && !Busy[idx]) begin f = 1; s = idx[1:0]; end
    end
    e.vj = (tj == 0) ? Rs_Qi_data[rj*16 +: 16] : 16'hFFF0;
    e.vk = (tk == 0) ? Rs_Qi_data[rk*16 +: 16] : 16'hFFF0;
    e.qj = tj; e.qk = tk;
    haz = 0;
`ifdef CDB_BYPASS_EN
    if (CDB_Valid && tj != 0 && CDB_Tag == tj) begin e.vj = CDB_Data; e.qj = 0; end
    if (CDB_Valid && tk != 0 && CDB_Tag == tk) begin e.vk = CDB_Data; e.qk = 0; end
`else
    haz = CDB_Valid && ((tj != 0 && CDB_Tag == tj) || (tk != 0 && CDB_Tag == tk));
`endif
    nop = (op == 3'b000);
    iss = Instr_Valid && (nop || (f && !haz));
    e.nop = nop; e.op = op; e.ri = ri; e.tag = {1'b0, s} + 3'd1;
    if (nop) begin
      e.vj = h_vj; e.vk = h_vk; e.qj = h_qj; e.qk = h_qk;
      e.op = h_op; e.ri = h_ri; e.tag = h_tag;
    end
    if (iss) begin
      sb.push_back(e);
      if (!nop) begin
        h_vj = e.vj; h_vk = e.vk; h_qj = e.qj; h_qk = e.qk;
        h_op = e.op; h_ri = e.ri; h_tag = e.tag;
        m_rr = s + 2'd1;
      end
    end

    @(posedge Clock); #1;
    if (m_state == 2 && m_stall != 8'hFF) m_stall++;
    m_state = iss ? 1 : (Instr_Valid ? 2 : 0);

    check("pop", Pop, iss);
    check("stall_count", Stall_count, m_stall);
    check("en_vq", Enable_VQ, (iss && !nop) ? (4'b0001 << s) : 4'b0000);
    check("r_enable", R_enable_despacho, iss && !nop);
    if (Pop) begin
      check("sb_level", sb.size(), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("vj", Vj, e.vj);
        check("vk", Vk, e.vk);
        check("qj", Qj, e.qj);
        check("qk", Qk, e.qk);
        check("ufop", Ufop, e.op);
        check("r_target", R_target_despacho, e.ri);
        check("r_tag", R_res_station_despacho, e.tag);
      end
    end
    if (iss && !nop && track_busy) Busy[s] = 1'b1;
    if (iss) Instr_Valid = 1'b0;
  endtask

  task automatic issue_bounded();
    for (int n = 0; n < 6 && Instr_Valid; n++) step();
    check("issue_timeout", Instr_Valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    Instr_Valid = 0; Instrucao_Despachada = '0; Rs_Qi = '0; Busy = '0;
    CDB_Valid = 0; CDB_Tag = 0; CDB_Data = '0; track_busy = 1;
    for (int r = 0; r < 8; r++) Rs_Qi_data[r*16 +: 16] = 16'h0100 + 16'(r);
    Rs_Qi_data[1*16 +: 16] = 16'd5;
    Rs_Qi_data[2*16 +: 16] = 16'd7;
    do_reset();
    do_reset();

    // Single issue, then fill all four stations back to back
    load(3'b001, 3'd3, 3'd1, 3'd2); step();
    load(3'b010, 3'd4, 3'd2, 3'd3); step();
    load(3'b101, 3'd6, 3'd6, 3'd7); step();
    Rs_Qi[5*3 +: 3] = 3'd4;
    load(3'b111, 3'd1, 3'd0, 3'd5); step();

    // All busy: stall, then free station 2
    load(3'b100, 3'd2, 3'd3, 3'd4);
    repeat (3) step();
    Busy[2] = 1'b0;
    step();

    // rr_ptr is now 3: with stations 0 and 3 free, station 3 must be chosen
    Busy = 4'b0110;
    load(3'b110, 3'd0, 3'd1, 3'd1); step();
    Busy = 4'b0000; track_busy = 0;
    Rs_Qi[5*3 +: 3] = 3'd0;

    // Producer of Rj broadcasting on the CDB at issue time
    Rs_Qi[1*3 +: 3] = 3'd2;
    CDB_Valid = 1; CDB_Tag = 3'd2; CDB_Data = 16'h00AA;
    load(3'b010, 3'd5, 3'd1, 3'd0); step();
    CDB_Valid = 0;
    Rs_Qi[1*3 +: 3] = 3'd0;
    Rs_Qi_data[1*16 +: 16] = 16'h00AA;
    issue_bounded();

    // NOP: Pop only
    load(3'b000, 3'd7, 3'd6, 3'd5); step();
    Instr_Valid = 0; step();

    // Reset while stalled drops the instruction
    Busy = 4'b1111;
    load(3'b001, 3'd1, 3'd2, 3'd3);
    step(); step();
    do_reset();
    Busy = 4'b0000;
    step();

    // Ri==Rj: operand sees the old producer, rename gets the new tag
    Rs_Qi[4*3 +: 3] = 3'd3;
    load(3'b011, 3'd4, 3'd4, 3'd0); step();
    Instr_Valid = 0; step();

    check("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
